// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-port arbiter sequencing accesses to a single data memory port
// through IDLE -> ACCESS -> RESP, with the read data and a one-cycle ack returned in RESP.
module data_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic              grant_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              last;
    logic              win;
    logic              win_we;
    logic [DATA_W-1:0] rdata;

    // On contention the port that was not granted last wins.
    assign win      = (m0_req & m1_req) ? ~last : m1_req;
    assign win_we   = win ? m1_we : m0_we;
    assign m0_rdata = rdata;
    assign m1_rdata = rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            last            <= 1'b1;
            grant_id        <= 1'b0;
            mem_access_addr <= '0;
            mem_write_data  <= '0;
            mem_write_en    <= 1'b0;
            mem_read        <= 1'b0;
            rdata           <= '0;
            busy            <= 1'b0;
            m0_ack          <= 1'b0;
            m1_ack          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (m0_req | m1_req) begin
                    state           <= ACCESS;
                    last            <= win;
                    grant_id        <= win;
                    mem_access_addr <= win ? m1_addr : m0_addr;
                    mem_write_data  <= win ? m1_wdata : m0_wdata;
                    mem_write_en    <= win_we;
                    mem_read        <= ~win_we;
                    busy            <= 1'b1;
                end
                ACCESS: begin
                    if (mem_read) rdata <= mem_read_data;
                    state        <= RESP;
                    mem_write_en <= 1'b0;
                    mem_read     <= 1'b0;
                    m0_ack       <= ~grant_id;
                    m1_ack       <= grant_id;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed stimulus with a queue of expected acks checked by a negedge monitor,
// against a small behavioural memory.
module tb_data_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_ack, m1_ack, mem_write_en, mem_read, busy, grant_id;
    logic [15:0] m0_rdata, m1_rdata, mem_access_addr, mem_write_data, mem_read_data;
    logic [15:0] mem [0:255];

    typedef struct {bit port; bit rd; logic [15:0] data; int cyc;} exp_t;
    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errs = 0;
    int   we_run = 0;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_read_data = mem[mem_access_addr[7:0]];
    always @(posedge clk) if (mem_write_en) mem[mem_access_addr[7:0]] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mem_read || mem_write_en) chk("strobe_excl", {31'd0, mem_read & mem_write_en}, 0);
        if (mem_write_en) we_run++;
        else if (we_run != 0) begin
            chk("we_pulse_len", we_run, 1);
            we_run = 0;
        end
        if (m0_ack || m1_ack) begin
            if (sb.size() == 0) chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 0);
            else begin
                e = sb.pop_front();
                chk("ack_port", {30'd0, m1_ack, m0_ack}, e.port ? 2 : 1);
                chk("grant_id", {31'd0, grant_id}, {31'd0, e.port});
                chk("ack_cycle", cyc, e.cyc);
                if (e.rd) chk("rdata", e.port ? m1_rdata : m0_rdata, e.data);
            end
        end
    end

    task automatic txn(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp);
        bit got = 0;
        @(negedge clk);
        sb.push_back('{p, !we, exp, cyc + 2});
        if (p) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
        else begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p ? m1_ack : m0_ack) begin got = 1; break; end
        end
        chk("txn_ack_seen", {31'd0, got}, 1);
        m0_req = 0;
        m1_req = 0;
    endtask

    task automatic chk_reset_outs(input string name);
        chk(name, {26'd0, busy, grant_id, m0_ack, m1_ack, mem_write_en, mem_read}, 0);
        chk({name, "_addr"}, mem_access_addr, 0);
        chk({name, "_wdata"}, mem_write_data, 0);
        chk({name, "_rdata"}, {m1_rdata, m0_rdata}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset_outs");
        rst_n = 1;
        // port 0 write then read back; port 1 write then port 0 read
        txn(0, 1, 16'h0004, 16'hA5A5, 16'h0);
        txn(0, 0, 16'h0004, 16'h0, 16'hA5A5);
        txn(1, 1, 16'h0007, 16'h1234, 16'h0);
        txn(0, 0, 16'h0007, 16'h0, 16'h1234);
        // simultaneous requests straight out of reset
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        c = cyc;
        m0_req = 1; m0_we = 0; m0_addr = 16'h0004;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0007;
        sb.push_back('{0, 1, 16'hA5A5, c + 2});
        sb.push_back('{1, 1, 16'h1234, c + 5});
        sb.push_back('{0, 1, 16'hA5A5, c + 8});
        sb.push_back('{1, 1, 16'h1234, c + 11});
        repeat (11) @(negedge clk);
        m0_req = 0;
        m1_req = 0;
        repeat (2) @(negedge clk);
        // saturation on port 0, single request from port 1
        c = cyc;
        m0_req = 1;
        sb.push_back('{0, 1, 16'hA5A5, c + 2});
        sb.push_back('{1, 1, 16'h1234, c + 5});
        sb.push_back('{0, 1, 16'hA5A5, c + 8});
        @(negedge clk);
        m1_req = 1;
        repeat (4) @(negedge clk);
        m1_req = 0;
        repeat (3) @(negedge clk);
        m0_req = 0;
        repeat (3) @(negedge clk);
        chk("sat_idle", {31'd0, busy}, 0);
        chk("sat_queue_empty", sb.size(), 0);
        // reset during ACCESS of a port 0 write
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 16'h0002; m0_wdata = 16'hFFFF;
        @(negedge clk);
        chk("rst_mid_we", {31'd0, mem_write_en}, 1);
        #2 rst_n = 0;
        m0_req = 0;
        #1 chk_reset_outs("rst_mid_outs");
        @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        chk("rst_mid_idle", {31'd0, busy}, 0);
        // port 1 read with req dropped during ACCESS
        c = cyc;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0007;
        sb.push_back('{1, 1, 16'h1234, c + 2});
        @(negedge clk);
        m1_req = 0;
        repeat (6) @(negedge clk);
        chk("drop_idle", {31'd0, busy}, 0);
        chk("final_queue_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port round-robin arbiter and access sequencer for the 16-bit data memory. It shares the single memory port (shared address bus, write data, write enable, read strobe, read data) between two requesters, e.g. the core load/store stage (port 0) and a debug/DMA loader (port 1). It serialises their accesses through a three-state FSM and returns read data with a one-cycle acknowledge.

## Interface
- ADDR_W, 16, address width of requesters and memory
- DATA_W, 16, data width of requesters and memory

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m0_req  in  1  port 0 request; hold high with payload stable until m0_ack
- m0_we  in  1  port 0: 1 = write, 0 = read
- m0_addr  in  ADDR_W  port 0 address
- m0_wdata  in  DATA_W  port 0 write data
- m0_ack  out  1  port 0 one-cycle completion pulse
- m0_rdata  out  DATA_W  read data; valid only while m0_ack=1 for a read
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as port 0, for port 1
- mem_access_addr  out  ADDR_W  memory address, shared by read and write
- mem_write_data  out  DATA_W  memory write data
- mem_write_en  out  1  memory write enable
- mem_read  out  1  memory read strobe
- mem_read_data  in  DATA_W  memory read data, combinational from address
- busy  out  1  high in ACCESS and RESP
- grant_id  out  1  port index of the current or most recent grant

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If any req=1, select a winner, latch its we/addr/wdata into internal registers, set grant_id, and go to ACCESS.
  - Otherwise stay in IDLE.
- Selection is round-robin with a last-grant pointer.
  - Only one req: that port wins.
  - Both req: the port not granted last wins.
  - The pointer resets to 1, so port 0 wins the first contention.
  - The pointer updates on every grant.
- ACCESS:
  - mem_access_addr and mem_write_data are driven from the latched registers.
  - mem_write_en = latched we; mem_read = ~latched we.
  - For a read, mem_read_data is captured into the shared rdata register at the closing edge.
  - Go to RESP.
- RESP:
  - The winner's ack is high for exactly one cycle; mem_write_en=0 and mem_read=0.
  - Go to IDLE.
- m0_rdata and m1_rdata are both driven from the shared rdata register. A write does not modify rdata.
- Payload and req changes during ACCESS/RESP are ignored. If req drops mid-transaction, the transaction still completes and ack still pulses.
- req high in the cycle after ack (IDLE) is a new transaction.
- A non-winning req stays pending, with no timeout.
- mem_access_addr and mem_write_data hold their latched values outside ACCESS. Only mem_write_en and mem_read qualify them.

## Timing
- Reset values:
  - state = IDLE; busy = 0; grant_id = 0; m0_ack = m1_ack = 0
  - rdata = 0, so m0_rdata = m1_rdata = 0
  - mem_access_addr = 0; mem_write_data = 0; mem_write_en = 0; mem_read = 0
  - rr pointer = 1
- Latency, with req sampled high in IDLE at cycle 0:
  - cycle 1 = ACCESS (memory strobes high);
  - cycle 2 = RESP (ack high, rdata valid);
  - cycle 3 = IDLE.
  - Minimum spacing between grants is 3 cycles.
- The requester must deassert req, or present a new payload, by the edge ending its ack cycle.
- All outputs are decoded from registered state and latches; there is no combinational path from any req to any mem_* output.
- mem_write_en is high for exactly one cycle per write. mem_read and mem_write_en are never high together.
- Asynchronous reset in ACCESS or RESP:
  - all outputs go to their reset values immediately and no ack is issued;
  - a write in flight may or may not have reached memory, so the requester must reissue.

## Test plan
- Write then read back on port 0: write addr 0x0004 data 0xA5A5, then read 0x0004. Expect mem_write_en high for exactly 1 cycle, m0_ack in cycle 2 of each transaction, and m0_rdata = 0xA5A5 with ack.
- Cross-port coherence: port 1 writes 0x1234 to 0x0007; port 0 then reads 0x0007. Expect m0_rdata = 0x1234 and m1_ack never high during port 0's transaction.
- Simultaneous requests: m0_req and m1_req asserted together in the first cycle after reset, both held. Expect grant order 0,1,0,1 with acks at cycles 2, 5, 8, 11 and grant_id alternating.
- Fairness under saturation: m0_req held high continuously, m1_req raised once. Expect port 1 granted no later than the grant following port 0's current transaction.
- Reset mid-access: assert rst_n=0 during ACCESS of a port 0 write of 0xFFFF to 0x0002. Expect all outputs at reset values immediately, no m0_ack, and state IDLE after release.
- Dropped request: m1 read of 0x0007 with m1_req deasserted during ACCESS. Expect the transaction to complete with m1_ack pulsing once, m1_rdata = 0x1234, and no further grants.
